// File: rtl/xor_response_checker.sv
// Response checker for a two-input XOR gate: it counts the accepted samples and the mismatches,
// tracks which input combinations were seen, and registers a pass/fail verdict.
// Optional first-failure capture ports: define XOR_CHK_FIRST_FAIL_EN.
//
// Handshake: a sample is accepted on a rising edge where in_valid && in_ready.
// in_ready is high only in RUN. in_valid without in_ready is dropped and not counted.
module xor_response_checker #(
    parameter int CNT_W       = 8,
    parameter int EXP_VECTORS = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_valid,
    input  logic             a,
    input  logic             b,
    input  logic             y,
    output logic             in_ready,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             mismatch,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] vec_count,
    output logic [3:0]       coverage,
`ifdef XOR_CHK_FIRST_FAIL_EN
    output logic             first_fail_valid,
    output logic [CNT_W-1:0] first_fail_idx,
    output logic [1:0]       first_fail_ab,
`endif
    output logic [1:0]       state_dbg
);

    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_RUN  = 2'b01;
    localparam logic [1:0] S_DONE = 2'b10;

    localparam logic [CNT_W-1:0] EXP_CNT = CNT_W'(EXP_VECTORS);

    logic [1:0]       state;
    logic             accept;
    logic             fail;
    logic [1:0]       ab;
    logic [CNT_W-1:0] vec_next;
    logic [CNT_W-1:0] err_next;
    logic [3:0]       cov_next;

    assign state_dbg = state;

    always_comb begin
        ab       = {a, b};
        accept   = 1'b0;
        fail     = 1'b0;
        vec_next = vec_count + 1'b1;
        err_next = err_count;
        cov_next = coverage | (4'b0001 << ab);
        if (state == S_RUN && in_valid && in_ready) begin
            accept = 1'b1;
            fail   = (y != (a ^ b));
        end
        // Saturate rather than wrap, so that a full counter can never read back as a clean run.
        if (fail && err_count != {CNT_W{1'b1}}) begin
            err_next = err_count + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            in_ready  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            mismatch  <= 1'b0;
            err_count <= '0;
            vec_count <= '0;
            coverage  <= 4'b0000;
        end else begin
            mismatch <= 1'b0;
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state     <= S_RUN;
                        in_ready  <= 1'b1;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        pass      <= 1'b0;
                        err_count <= '0;
                        vec_count <= '0;
                        coverage  <= 4'b0000;
                    end
                end
                S_RUN: begin
                    if (accept) begin
                        vec_count <= vec_next;
                        err_count <= err_next;
                        coverage  <= cov_next;
                        mismatch  <= fail;
                        // The verdict is registered in the same update as the last count.
                        if (vec_next == EXP_CNT) begin
                            state    <= S_DONE;
                            in_ready <= 1'b0;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                            pass     <= (err_next == '0) && (cov_next == 4'b1111);
                        end
                    end
                end
                default: begin
                    state    <= S_IDLE;
                    in_ready <= 1'b0;
                    busy     <= 1'b0;
                    done     <= 1'b0;
                end
            endcase
        end
    end

`ifdef XOR_CHK_FIRST_FAIL_EN
    always_ff @(posedge clk) begin
        if (rst || ((state != S_RUN) && start)) begin
            first_fail_valid <= 1'b0;
            first_fail_idx   <= '0;
            first_fail_ab    <= 2'b00;
        end else if (fail && !first_fail_valid) begin
            first_fail_valid <= 1'b1;
            first_fail_idx   <= vec_count;
            first_fail_ab    <= ab;
        end
    end
`endif

endmodule

// File: tb/tb_xor_response_checker.sv
// Directed bench for xor_response_checker: table-driven runs, followed by hand-written
// sequences for handshake gaps, reset mid-run, and start pulsed during a run.
module tb_xor_response_checker;

    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst, start, in_valid, a, b, y;
    logic             in_ready, busy, done, pass, mismatch;
    logic [CNT_W-1:0] err_count, vec_count;
    logic [3:0]       coverage;
    logic [1:0]       state_dbg;
`ifdef XOR_CHK_FIRST_FAIL_EN
    logic             first_fail_valid;
    logic [CNT_W-1:0] first_fail_idx;
    logic [1:0]       first_fail_ab;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    xor_response_checker #(.CNT_W(CNT_W), .EXP_VECTORS(4)) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
        .a(a), .b(b), .y(y),
        .in_ready(in_ready), .busy(busy), .done(done), .pass(pass),
        .mismatch(mismatch), .err_count(err_count), .vec_count(vec_count),
        .coverage(coverage),
`ifdef XOR_CHK_FIRST_FAIL_EN
        .first_fail_valid(first_fail_valid), .first_fail_idx(first_fail_idx),
        .first_fail_ab(first_fail_ab),
`endif
        .state_dbg(state_dbg)
    );

    // Bit i of a/b/y holds vector i. The exp_* fields are computed by hand.
    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] y;
        logic [7:0] exp_err;
        logic [3:0] exp_cov;
        logic       exp_pass;
        logic [7:0] exp_ff_idx;
        logic [1:0] exp_ff_ab;
    } run_t;

    run_t runs[4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_values();
        chk("rst_in_ready", in_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_pass", pass, 0);
        chk("rst_mismatch", mismatch, 0);
        chk("rst_err", err_count, 0);
        chk("rst_vec", vec_count, 0);
        chk("rst_cov", coverage, 0);
        chk("rst_state", state_dbg, 2'b00);
    endtask

    task automatic drive(input logic v, input logic ia, input logic ib, input logic iy);
        in_valid = v;
        a = ia;
        b = ib;
        y = iy;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start_busy", busy, 1);
        chk("start_ready", in_ready, 1);
        chk("start_done", done, 0);
        chk("start_vec", vec_count, 0);
        chk("start_err", err_count, 0);
        chk("start_cov", coverage, 0);
    endtask

    task automatic do_run(input run_t r);
        logic m;
        do_start();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, r.a[i], r.b[i], r.y[i]);
            tick();
            m = (r.y[i] !== (r.a[i] ^ r.b[i]));
            chk("vec_mismatch", mismatch, m);
            chk("vec_count", vec_count, i + 1);
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        chk("run_done", done, 1);
        chk("run_ready", in_ready, 0);
        chk("run_busy", busy, 0);
        chk("run_err", err_count, r.exp_err);
        chk("run_cov", coverage, r.exp_cov);
        chk("run_pass", pass, r.exp_pass);
        chk("run_state", state_dbg, 2'b10);
`ifdef XOR_CHK_FIRST_FAIL_EN
        chk("ff_valid", first_fail_valid, (r.exp_err != 0));
        if (r.exp_err != 0) begin
            chk("ff_idx", first_fail_idx, r.exp_ff_idx);
            chk("ff_ab", first_fail_ab, r.exp_ff_ab);
        end
`endif
        tick();
        chk("run_mismatch_clear", mismatch, 0);
    endtask

    initial begin
        runs[0] = '{a: 4'b1100, b: 4'b1010, y: 4'b0110, exp_err: 8'd0, exp_cov: 4'b1111,
                    exp_pass: 1'b1, exp_ff_idx: 8'd0, exp_ff_ab: 2'b00};
        runs[1] = '{a: 4'b1100, b: 4'b1010, y: 4'b1110, exp_err: 8'd1, exp_cov: 4'b1111,
                    exp_pass: 1'b0, exp_ff_idx: 8'd3, exp_ff_ab: 2'b11};
        runs[2] = '{a: 4'b0000, b: 4'b1111, y: 4'b1111, exp_err: 8'd0, exp_cov: 4'b0010,
                    exp_pass: 1'b0, exp_ff_idx: 8'd0, exp_ff_ab: 2'b00};
        runs[3] = runs[0];

        rst = 1'b1;
        start = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        check_reset_values();
        rst = 1'b0;
        tick();
        check_reset_values();

        // Correct, faulty, incomplete, then restart from DONE with a correct run.
        for (int r = 0; r < 4; r++) begin
            do_run(runs[r]);
        end

        // A sample offered in DONE is dropped.
        drive(1'b1, 1'b1, 1'b1, 1'b1);
        tick();
        chk("done_drop_vec", vec_count, 4);
        chk("done_drop_mis", mismatch, 0);
        chk("done_drop_err", err_count, 0);
        drive(1'b0, 1'b0, 1'b0, 1'b0);

        // Handshake gaps: in_valid is held in IDLE, then toggles 1/0 during RUN.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        drive(1'b1, 1'b1, 1'b1, 1'b0);
        tick();
        tick();
        chk("idle_drop_vec", vec_count, 0);
        chk("idle_drop_state", state_dbg, 2'b00);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("gap_start_vec", vec_count, 0);
        for (int i = 0; i < 8; i++) begin
            drive(~i[0], i[2], i[1], i[2] ^ i[1]);
            tick();
            if (i == 1) chk("gap_vec_mid", vec_count, 1);
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        chk("gap_vec", vec_count, 4);
        chk("gap_done", done, 1);
        chk("gap_pass", pass, 1);
        chk("gap_cov", coverage, 4'b1111);

        // Reset mid-run: rst wins over start and in_valid.
        do_start();
        drive(1'b1, 1'b0, 1'b1, 1'b0);
        tick();
        drive(1'b1, 1'b1, 1'b0, 1'b1);
        tick();
        chk("mid_vec2", vec_count, 2);
        chk("mid_err1", err_count, 1);
        rst = 1'b1;
        start = 1'b1;
        tick();
        rst = 1'b0;
        start = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        check_reset_values();
        do_run(runs[0]);

        // start pulsed during RUN is ignored.
        do_start();
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b1, 1'b0, 1'b1, 1'b1);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("run_start_vec", vec_count, 2);
        chk("run_start_cov", coverage, 4'b0011);
        drive(1'b1, 1'b1, 1'b0, 1'b1);
        tick();
        drive(1'b1, 1'b1, 1'b1, 1'b0);
        tick();
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        chk("run_start_done", done, 1);
        chk("run_start_pass", pass, 1);
        chk("run_start_vec4", vec_count, 4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/xor_response_checker.md
# xor_response_checker

Synthesizable response checker for the two-input XOR gate: the consuming end of the gate-level stimulus/response interface. It accepts (a, b, y) samples over a valid/ready handshake and compares y against a^b. It counts vectors and mismatches, tracks which of the four input combinations have been exercised, and reports a registered pass/fail verdict. It sits beside the gate under test in on-chip or FPGA self-test wrappers, replacing manual waveform inspection.

## Interface
- CNT_W, 8, width of the vector and error counters; must satisfy EXP_VECTORS ≤ 2^CNT_W − 1
- EXP_VECTORS, 4, number of accepted vectors that completes a run; minimum 1
- clk  input  1  single clock; all logic on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  begins a run from IDLE or DONE; ignored in RUN
- in_valid  input  1  sample present on a, b, y
- a  input  1  gate input a as driven
- b  input  1  gate input b as driven
- y  input  1  observed gate output
- in_ready  output  1  checker accepts a sample this cycle
- busy  output  1  run in progress
- done  output  1  run complete; verdict valid
- pass  output  1  verdict: no mismatches and full coverage
- mismatch  output  1  one-cycle pulse per failing vector
- err_count  output  CNT_W  mismatching vectors, saturating
- vec_count  output  CNT_W  vectors accepted this run
- coverage  output  4  bit {a,b} set once that combination is accepted

## Operation
- States: IDLE, RUN, DONE. Reset enters IDLE.
- IDLE:
  - in_ready=0, busy=0, done=0.
  - start=1 → RUN. Clear err_count, vec_count, coverage, pass.
- RUN:
  - in_ready=1, busy=1.
  - Accept occurs when in_valid && in_ready.
  - On accept: exp = a ^ b. vec_count += 1; coverage[{a,b}] ← 1.
  - If y != exp: err_count += 1, saturating at all ones; mismatch pulses.
  - When the accepted vector makes vec_count == EXP_VECTORS → DONE.
  - start is ignored.
  - in_valid while in_ready=0 is not an accept; the sample is dropped and nothing is counted.
- DONE:
  - in_ready=0, busy=0, done=1.
  - pass = (err_count == 0) && (coverage == 4'b1111).
  - Counters and coverage hold their values.
  - start=1 → RUN, clearing everything as on entry from IDLE.
- Fewer than four vector types in a run gives pass=0 even with zero errors.
- Repeated identical vectors count toward vec_count; coverage bits are idempotent.

## Timing
- Reset values: in_ready=0, busy=0, done=0, pass=0, mismatch=0, err_count=0, vec_count=0, coverage=4'b0000. State = IDLE.
- All outputs are registered.
- start sampled at edge N:
  - busy=1 and in_ready=1 from edge N+1.
  - Counters read 0 from edge N+1.
- Accept at edge N:
  - vec_count, coverage and err_count are updated after edge N.
  - mismatch is high for exactly the cycle following edge N.
- Final accept at edge N:
  - done=1, pass valid and in_ready=0 after edge N, i.e. the same update as the last count.
  - No further sample is accepted.
- Back-to-back accepts every cycle are supported. Throughput is one vector per clock.
- rst=1 mid-run overrides all other inputs. Any partial run is discarded.
- start and rst high together: rst wins.
- err_count saturation only matters when CNT_W is reduced; the verdict stays fail.

## Configuration
- Macro: XOR_CHK_FIRST_FAIL_EN.
- Defined:
  - Adds output ports first_fail_valid (1), first_fail_idx (CNT_W) and first_fail_ab (2).
  - On the first mismatch of a run, these capture: valid=1, idx = the vec_count value before increment (0-based), ab = {a,b}.
  - Later mismatches do not overwrite the capture.
  - The capture is cleared on rst and on run start.
  - Capture timing matches mismatch.
- Undefined: these ports and registers do not exist; all other behaviour is identical.

## Test plan
- Correct exhaustive run: start, then (0,0,0), (0,1,1), (1,0,1), (1,1,0) on consecutive cycles → done=1, pass=1, err_count=0, vec_count=4, coverage=4'b1111, mismatch never high.
- Faulty gate: same a/b sequence with y=a|b, so (1,1) gives y=1 → a single mismatch pulse the cycle after the 4th accept, err_count=1, pass=0. With the macro: first_fail_idx=3, first_fail_ab=2'b11.
- Incomplete coverage: four correct vectors of (0,1,1) → done=1, pass=0, coverage=4'b0010, err_count=0.
- Handshake gaps: in_valid toggled 1/0 across 8 cycles with 4 correct vectors; in_valid held in IDLE before start → only the 4 RUN accepts counted; vec_count=4; pass=1.
- Reset mid-run: rst=1 after 2 accepts → all outputs at reset values next cycle, state IDLE. A following start and a full correct run → pass=1.
- Restart from DONE: after a failing run, start and a correct run → err_count=0, pass=1. Start pulsed during RUN has no effect.
